// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state encodings, master ids and byte-merge helper for mem_arbiter
package mem_arb_pkg;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] MERGE  = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    localparam logic M_IFETCH = 1'b0;
    localparam logic M_LSU    = 1'b1;

    localparam logic [3:0] BE_FULL = 4'b1111;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  be);
        logic [31:0] r;
        r = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                r[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// rtl/mem_arb_rr.sv - 2-way round-robin grant with last-grant register
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] ready_o,
    output logic       gnt_o,
    output logic       fire_o
);

    logic last_q;

    always_comb begin
        gnt_o = M_IFETCH;
        if (req_i[0] && req_i[1]) begin
            gnt_o = ~last_q;
        end else if (req_i[1]) begin
            gnt_o = M_LSU;
        end
        ready_o[0] = en_i && req_i[0] && (gnt_o == M_IFETCH);
        ready_o[1] = en_i && req_i[1] && (gnt_o == M_LSU);
        fire_o     = |(req_i & ready_o);
    end

    // Last-grant starts at the LSU so the fetch port wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= M_LSU;
        end else if (fire_o) begin
            last_q <= gnt_o;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-master single-outstanding memory arbiter with read-modify-write
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter logic [31:0] MEM_BASE = 32'h9000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req_valid,
    output logic        m0_req_ready,
    input  logic [31:0] m0_addr,
    output logic        m0_resp_valid,
    output logic [31:0] m0_resp_data,
    output logic        m0_err,
    input  logic        m1_req_valid,
    output logic        m1_req_ready,
    input  logic [31:0] m1_addr,
    input  logic        m1_we,
    input  logic [3:0]  m1_be,
    input  logic [31:0] m1_wdata,
    output logic        m1_resp_valid,
    output logic [31:0] m1_resp_data,
    output logic        m1_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata,
    input  logic        mem_sel
);

    logic [1:0]  state_q, state_d;
    logic        id_q;
    logic [31:0] addr_q;
    logic        we_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic [1:0]  ready;
    logic        gnt;
    logic        fire;
    logic        full_store;
    logic        partial_store;

    mem_arb_rr u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (state_q == IDLE),
        .req_i   ({m1_req_valid, m0_req_valid}),
        .ready_o (ready),
        .gnt_o   (gnt),
        .fire_o  (fire)
    );

    assign m0_req_ready  = ready[0];
    assign m1_req_ready  = ready[1];
    assign full_store    = we_q && (be_q == BE_FULL);
    assign partial_store = we_q && (be_q != 4'b0000) && (be_q != BE_FULL);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (fire) state_d = ACCESS;
            ACCESS:  state_d = (mem_sel && partial_store) ? MERGE : RESP;
            MERGE:   state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            id_q    <= M_IFETCH;
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= 4'b0000;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (fire) begin
                id_q <= gnt;
                if (gnt == M_LSU) begin
                    addr_q  <= m1_addr;
                    we_q    <= m1_we;
                    be_q    <= m1_be;
                    wdata_q <= m1_wdata;
                end else begin
                    addr_q  <= m0_addr;
                    we_q    <= 1'b0;
                    be_q    <= 4'b0000;
                    wdata_q <= '0;
                end
            end
            // A miss returns zero data; the old word is kept for merge and store responses.
            if (state_q == ACCESS) begin
                rdata_q <= mem_sel ? mem_rdata : '0;
                err_q   <= ~mem_sel;
            end
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        if (state_q == ACCESS) begin
            mem_addr = addr_q & ~32'h3;
            if (full_store && mem_sel) begin
                mem_we    = 1'b1;
                mem_wdata = wdata_q;
            end
        end else if (state_q == MERGE) begin
            mem_addr  = addr_q & ~32'h3;
            mem_we    = 1'b1;
            mem_wdata = byte_merge(rdata_q, wdata_q, be_q);
        end
    end

    always_comb begin
        m0_resp_valid = (state_q == RESP) && (id_q == M_IFETCH);
        m1_resp_valid = (state_q == RESP) && (id_q == M_LSU);
        m0_resp_data  = m0_resp_valid ? rdata_q : '0;
        m1_resp_data  = m1_resp_valid ? rdata_q : '0;
        m0_err        = m0_resp_valid && err_q;
        m1_err        = m1_resp_valid && err_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

    localparam logic [31:0] BASE = 32'h9000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req_valid, m0_req_ready;
    logic [31:0] m0_addr;
    logic        m0_resp_valid, m0_err;
    logic [31:0] m0_resp_data;
    logic        m1_req_valid, m1_req_ready;
    logic [31:0] m1_addr;
    logic        m1_we;
    logic [3:0]  m1_be;
    logic [31:0] m1_wdata;
    logic        m1_resp_valid, m1_err;
    logic [31:0] m1_resp_data;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we, mem_sel;

    logic        preload;
    logic [31:0] mem [0:63];
    int          we_cnt = 0;
    int          r1_cnt = 0;
    int          n_pass = 0;
    int          n_total = 0;
    int          w0, r1;

    always #5 clk = ~clk;

    mem_arbiter #(.MEM_BASE(BASE)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .m0_req_valid  (m0_req_valid),
        .m0_req_ready  (m0_req_ready),
        .m0_addr       (m0_addr),
        .m0_resp_valid (m0_resp_valid),
        .m0_resp_data  (m0_resp_data),
        .m0_err        (m0_err),
        .m1_req_valid  (m1_req_valid),
        .m1_req_ready  (m1_req_ready),
        .m1_addr       (m1_addr),
        .m1_we         (m1_we),
        .m1_be         (m1_be),
        .m1_wdata      (m1_wdata),
        .m1_resp_valid (m1_resp_valid),
        .m1_resp_data  (m1_resp_data),
        .m1_err        (m1_err),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_we        (mem_we),
        .mem_rdata     (mem_rdata),
        .mem_sel       (mem_sel)
    );

    // Memory window model: hit on 0x9xxx_xxxx, asynchronous read, write on rising edge.
    assign mem_sel   = (mem_addr[31:28] == BASE[31:28]);
    assign mem_rdata = mem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (preload) begin
            mem[0]  <= 32'h5555_5555;
            mem[4]  <= 32'hDEAD_BEEF;
            mem[8]  <= 32'h0808_0808;
            mem[12] <= 32'h1122_3344;
            mem[16] <= 32'h0102_0304;
            mem[20] <= 32'h0000_0000;
            mem[24] <= 32'h7777_7777;
        end else if (mem_we && mem_sel) begin
            mem[mem_addr[7:2]] <= mem_wdata;
        end
        if (mem_we) we_cnt <= we_cnt + 1;
        if (m1_resp_valid) r1_cnt <= r1_cnt + 1;
    end

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    initial begin
        rst_n = 1'b0; preload = 1'b1;
        m0_req_valid = 1'b0; m0_addr = '0;
        m1_req_valid = 1'b0; m1_addr = '0; m1_we = 1'b0; m1_be = 4'h0; m1_wdata = '0;
        repeat (2) @(negedge clk);
        preload = 1'b0;
        chk1 ("rst_mem_we",    mem_we, 1'b0);
        chk32("rst_mem_addr",  mem_addr, 32'h0);
        chk32("rst_mem_wdata", mem_wdata, 32'h0);
        chk1 ("rst_m0_rv",     m0_resp_valid, 1'b0);
        chk1 ("rst_m1_rv",     m1_resp_valid, 1'b0);
        chk32("rst_m1_data",   m1_resp_data, 32'h0);
        chk1 ("rst_m1_err",    m1_err, 1'b0);
        rst_n = 1'b1;

        // m0 fetch hit
        @(negedge clk);
        m0_req_valid = 1'b1; m0_addr = BASE + 32'h10;
        #1;
        chk1("t1_m0_ready", m0_req_ready, 1'b1);
        chk1("t1_m1_ready", m1_req_ready, 1'b0);
        @(negedge clk);
        m0_req_valid = 1'b0;
        chk32("t1_acc_addr", mem_addr, 32'h9000_0010);
        chk1 ("t1_acc_rv",   m0_resp_valid, 1'b0);
        @(negedge clk);
        chk1 ("t1_rv",      m0_resp_valid, 1'b1);
        chk32("t1_data",    m0_resp_data, 32'hDEAD_BEEF);
        chk1 ("t1_err",     m0_err, 1'b0);
        chk1 ("t1_m1_rv",   m1_resp_valid, 1'b0);
        chk32("t1_rsp_addr", mem_addr, 32'h0);
        @(negedge clk);
        chk1("t1_rv_drop", m0_resp_valid, 1'b0);

        // round-robin under continuous contention
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m0_req_valid = 1'b1; m0_addr = BASE + 32'h10;
        m1_req_valid = 1'b1; m1_addr = BASE + 32'h20; m1_we = 1'b0; m1_be = 4'hF;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk1("rr_m0_ready", m0_req_ready, (i % 2) == 0);
            chk1("rr_m1_ready", m1_req_ready, (i % 2) == 1);
            @(negedge clk);
            @(negedge clk);
            chk1("rr_m0_rv", m0_resp_valid, (i % 2) == 0);
            chk1("rr_m1_rv", m1_resp_valid, (i % 2) == 1);
            if ((i % 2) == 0) chk32("rr_m0_data", m0_resp_data, 32'hDEAD_BEEF);
            else              chk32("rr_m1_data", m1_resp_data, 32'h0808_0808);
            @(negedge clk);
        end
        m0_req_valid = 1'b0; m1_req_valid = 1'b0;

        // partial store be=0010
        m1_req_valid = 1'b1; m1_addr = BASE + 32'h30; m1_we = 1'b1;
        m1_be = 4'b0010; m1_wdata = 32'h0000_AB00;
        #1;
        chk1("ps_ready", m1_req_ready, 1'b1);
        @(negedge clk);
        m1_req_valid = 1'b0;
        chk1("ps_acc_we", mem_we, 1'b0);
        @(negedge clk);
        chk1 ("ps_mrg_we",    mem_we, 1'b1);
        chk32("ps_mrg_wdata", mem_wdata, 32'h1122_AB44);
        chk32("ps_mrg_addr",  mem_addr, 32'h9000_0030);
        chk1 ("ps_mrg_rv",    m1_resp_valid, 1'b0);
        @(negedge clk);
        chk1 ("ps_rv",   m1_resp_valid, 1'b1);
        chk32("ps_data", m1_resp_data, 32'h1122_3344);
        chk1 ("ps_err",  m1_err, 1'b0);
        chk32("ps_mem",  mem[12], 32'h1122_AB44);
        chk1 ("ps_rsp_we", mem_we, 1'b0);

        // load outside the window
        @(negedge clk);
        w0 = we_cnt;
        m1_req_valid = 1'b1; m1_addr = 32'h8000_0000; m1_we = 1'b0; m1_be = 4'hF;
        @(negedge clk);
        m1_req_valid = 1'b0;
        @(negedge clk);
        chk1 ("miss_rv",   m1_resp_valid, 1'b1);
        chk1 ("miss_err",  m1_err, 1'b1);
        chk32("miss_data", m1_resp_data, 32'h0);
        chk32("miss_we_cnt", we_cnt - w0, 32'h0);

        // be=0 store is a no-op
        @(negedge clk);
        w0 = we_cnt;
        m1_req_valid = 1'b1; m1_addr = BASE + 32'h40; m1_we = 1'b1;
        m1_be = 4'b0000; m1_wdata = 32'hFFFF_FFFF;
        @(negedge clk);
        m1_req_valid = 1'b0;
        chk1("be0_acc_we", mem_we, 1'b0);
        @(negedge clk);
        chk1 ("be0_rv",   m1_resp_valid, 1'b1);
        chk1 ("be0_err",  m1_err, 1'b0);
        chk32("be0_data", m1_resp_data, 32'h0102_0304);
        @(negedge clk);
        chk32("be0_we_cnt", we_cnt - w0, 32'h0);
        chk32("be0_mem",    mem[16], 32'h0102_0304);

        // full store, then reset during the next store's ACCESS
        m1_req_valid = 1'b1; m1_addr = BASE + 32'h50; m1_we = 1'b1;
        m1_be = 4'hF; m1_wdata = 32'hCAFE_F00D;
        @(negedge clk);
        m1_req_valid = 1'b0;
        chk1 ("fs_acc_we",    mem_we, 1'b1);
        chk32("fs_acc_wdata", mem_wdata, 32'hCAFE_F00D);
        @(negedge clk);
        chk1 ("fs_rv",  m1_resp_valid, 1'b1);
        chk32("fs_mem", mem[20], 32'hCAFE_F00D);
        @(negedge clk);
        r1 = r1_cnt;
        m1_req_valid = 1'b1; m1_addr = BASE + 32'h60; m1_wdata = 32'h1234_5678;
        @(negedge clk);
        chk1("rs_acc_we", mem_we, 1'b1);
        rst_n = 1'b0;
        m1_req_valid = 1'b0;
        #1;
        chk1 ("rs_we",    mem_we, 1'b0);
        chk32("rs_addr",  mem_addr, 32'h0);
        chk32("rs_wdata", mem_wdata, 32'h0);
        chk1 ("rs_rv",    m1_resp_valid, 1'b0);
        chk32("rs_data",  m1_resp_data, 32'h0);
        chk1 ("rs_err",   m1_err, 1'b0);
        @(negedge clk);
        chk32("rs_mem", mem[24], 32'h7777_7777);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk32("rs_no_resp", r1_cnt - r1, 32'h0);
        m0_req_valid = 1'b1; m0_addr = BASE + 32'h10;
        #1;
        chk1("rs_idle_ready", m0_req_ready, 1'b1);
        m0_req_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_BASE, default 32'h9000_0000, memory window base (documentation and bench only; decode is done by the memory via mem_sel).
REQ-002 SHALL have port clk  in  1  clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports m0_req_valid in 1, m0_req_ready out 1, m0_addr in 32: instruction-fetch port, read-only.
REQ-005 SHALL have ports m0_resp_valid out 1, m0_resp_data out 32, m0_err out 1: fetch response.
REQ-006 SHALL have ports m1_req_valid in 1, m1_req_ready out 1, m1_addr in 32, m1_we in 1, m1_be in 4, m1_wdata in 32: load/store port.
REQ-007 SHALL have ports m1_resp_valid out 1, m1_resp_data out 32, m1_err out 1: load/store response.
REQ-008 SHALL have ports mem_addr out 32, mem_wdata out 32, mem_we out 1, mem_rdata in 32 (asynchronous read), mem_sel in 1 (memory address-hit).

Function
REQ-009 SHALL use FSM states IDLE, ACCESS, MERGE, RESP.
REQ-010 SHALL, in IDLE, assert req_ready only to the granted master, combinationally; a handshake is valid&ready in the same cycle.
REQ-011 SHALL arbitrate round-robin: with one valid requester, grant it; with both valid, grant the master not granted last.
REQ-012 SHALL update last-grant only on a completed handshake.
REQ-013 SHALL, on handshake, register master id, address, we, be and wdata, then go to ACCESS.
REQ-014 SHALL drive mem_addr = {addr[31:2],2'b00} in ACCESS and MERGE; mem_addr = 0 in IDLE and RESP.
REQ-015 SHALL, in ACCESS, sample mem_rdata into the response register.
REQ-016 SHALL perform full-word stores (be=4'b1111) in ACCESS: mem_we=1, mem_wdata=wdata.
REQ-017 SHALL handle partial stores (be nonzero, not 1111) as ACCESS (read old word) -> MERGE (mem_we=1, each byte from wdata where be=1, else the old byte).
REQ-018 SHALL treat be=0 stores as no-ops: no mem_we, normal response.
REQ-019 SHALL raise err when mem_sel=0 in ACCESS: no write, skip MERGE, response data 0.
REQ-020 SHALL, in RESP, pulse resp_valid for exactly one cycle to the owning master only, with data and err valid in that cycle; then return to IDLE.
REQ-021 SHALL give the owning master a store response with resp_data equal to the word read in ACCESS.
REQ-022 SHALL meet latency from handshake cycle T: resp_valid at T+2 for loads and full stores, T+3 for partial stores.
REQ-023 SHALL accept a new request no earlier than the cycle after RESP (one outstanding request, no backpressure on responses).
REQ-024 SHALL hold mem_we=0 in every state except a write in ACCESS or MERGE.
REQ-025 SHALL ignore m0 writes (m0 has no write path); m1_we=0 is a load.

Reset
REQ-026 SHALL, on rst_n low at any time: state=IDLE, last-grant=m1 (m0 wins first tie), all resp_valid/err/resp_data=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-027 SHALL, on reset mid-operation, drop the in-flight request: no response, no further memory write after reset assertion.

Structure
REQ-028 SHALL use shared package mem_arb_pkg holding the state enum, master-id constants (M_IFETCH=0, M_LSU=1), and the byte-merge function.
REQ-029 SHALL contain one sub-module mem_arb_rr: 2-way round-robin grant logic with last-grant register.

Verification
REQ-030 SHALL test: m0 read 0x9000_0010, memory word 0xDEAD_BEEF -> m0_resp_valid at T+2, data 0xDEAD_BEEF, err 0.
REQ-031 SHALL test: both valid in the same cycle after reset -> m0 granted first, m1 granted next; repeat with both valid -> grants alternate m0,m1,m0,m1.
REQ-032 SHALL test: m1 store be=4'b0010, wdata 0x0000_AB00, to word 0x1122_3344 -> mem_we one cycle at T+2, memory becomes 0x1122_AB44, resp at T+3.
REQ-033 SHALL test: m1 load 0x8000_0000 with mem_sel=0 -> m1_err=1, data 0, mem_we never asserted.
REQ-034 SHALL test: full store 0xCAFE_F00D, then rst_n low in the ACCESS cycle of the next store -> no response, state IDLE, outputs at reset values.
REQ-035 SHALL test: be=0 store -> no mem_we, m1_resp_valid at T+2 with err 0.
